// File: rtl/spi_target_if.sv
// rtl/spi_target_if.sv - SPI pin and local register port bundle for spi_target
interface spi_target_if #(
    parameter int ADDR_W = 7
);
    logic              spi_cs_n;
    logic              spi_sck;
    logic              spi_mosi;
    logic              spi_miso;
    logic              spi_miso_oe;
    logic [ADDR_W-1:0] reg_addr;
    logic [7:0]        reg_wdata;
    logic              reg_we;
    logic              reg_re;
    logic [7:0]        reg_rdata;
    logic              busy;

    // Environment side: SPI master pins plus the register file answering reads
    modport master (
        output spi_cs_n, spi_sck, spi_mosi, reg_rdata,
        input  spi_miso, spi_miso_oe, reg_addr, reg_wdata, reg_we, reg_re, busy
    );

    // Target side: the spi_target block itself
    modport slave (
        input  spi_cs_n, spi_sck, spi_mosi, reg_rdata,
        output spi_miso, spi_miso_oe, reg_addr, reg_wdata, reg_we, reg_re, busy
    );
endinterface

// File: rtl/spi_target.sv
// rtl/spi_target.sv - SPI mode-0 target bridging to a local register port (option: SPI_TARGET_STATUS_EN)
module spi_target #(
    parameter int ADDR_W  = 7,
    parameter int SYNC_FF = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    spi_target_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_WR   = 2'd2,
        ST_RD   = 2'd3
    } state_t;

    logic [SYNC_FF-1:0] cs_sync_q;
    logic [SYNC_FF-1:0] sck_sync_q;
    logic [SYNC_FF-1:0] mosi_sync_q;

    state_t            state_q;
    logic              cs_prev_q;
    logic              sck_prev_q;
    logic [2:0]        bit_cnt_q;
    logic [7:0]        rx_sr_q;
    logic [7:0]        tx_sr_q;
    logic [7:0]        rd_buf_q;
    logic [ADDR_W-1:0] reg_addr_q;
    logic [7:0]        reg_wdata_q;
    logic              reg_we_q;
    logic              reg_re_q;
    logic              re_pend_q;
    logic              busy_q;
`ifdef SPI_TARGET_STATUS_EN
    logic [3:0]        xact_cnt_q;
    logic              got_byte_q;
`endif

    logic       cs_s;
    logic       sck_s;
    logic       mosi_s;
    logic       active;
    logic       cs_fall;
    logic       cs_rise;
    logic       sck_rise;
    logic       sck_fall;
    logic       byte_done;
    logic [7:0] rx_next;
    logic [7:0] status_byte;

    assign cs_s   = cs_sync_q[SYNC_FF-1];
    assign sck_s  = sck_sync_q[SYNC_FF-1];
    assign mosi_s = mosi_sync_q[SYNC_FF-1];

    // A rise of CS is still "active" for one cycle so a byte completing with it gets processed
    assign active    = (state_q != ST_IDLE);
    assign cs_fall   = cs_prev_q & ~cs_s;
    assign cs_rise   = ~cs_prev_q & cs_s;
    assign sck_rise  = active & ~sck_prev_q & sck_s;
    assign sck_fall  = active & ~cs_s & sck_prev_q & ~sck_s;
    assign rx_next   = {rx_sr_q[6:0], mosi_s};
    assign byte_done = sck_rise & (bit_cnt_q == 3'd7);

`ifdef SPI_TARGET_STATUS_EN
    assign status_byte = {4'hA, xact_cnt_q};
`else
    assign status_byte = 8'h00;
`endif

    // Pin synchronisers; CS resets low so a CS held low across reset is not seen as a fresh fall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_sync_q   <= '0;
            sck_sync_q  <= '0;
            mosi_sync_q <= '0;
        end else begin
            cs_sync_q   <= {cs_sync_q[SYNC_FF-2:0], bus.spi_cs_n};
            sck_sync_q  <= {sck_sync_q[SYNC_FF-2:0], bus.spi_sck};
            mosi_sync_q <= {mosi_sync_q[SYNC_FF-2:0], bus.spi_mosi};
        end
    end

    // Transaction FSM with shift registers, register-port strobes and address stepping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cs_prev_q   <= 1'b0;
            sck_prev_q  <= 1'b0;
            bit_cnt_q   <= 3'd0;
            rx_sr_q     <= 8'h00;
            tx_sr_q     <= 8'h00;
            rd_buf_q    <= 8'h00;
            reg_addr_q  <= '0;
            reg_wdata_q <= 8'h00;
            reg_we_q    <= 1'b0;
            reg_re_q    <= 1'b0;
            re_pend_q   <= 1'b0;
            busy_q      <= 1'b0;
`ifdef SPI_TARGET_STATUS_EN
            xact_cnt_q  <= 4'd0;
            got_byte_q  <= 1'b0;
`endif
        end else begin
            cs_prev_q  <= cs_s;
            sck_prev_q <= sck_s;
            reg_we_q   <= 1'b0;
            reg_re_q   <= 1'b0;
            re_pend_q  <= 1'b0;

            // Strobe aftermath fires regardless of CS so scheduled accesses always complete
            if (reg_we_q || reg_re_q) begin
                reg_addr_q <= reg_addr_q + ADDR_W'(1);
            end
            if (reg_re_q) begin
                rd_buf_q <= bus.reg_rdata;
            end
            if (re_pend_q) begin
                reg_re_q <= 1'b1;
            end

            if (sck_rise) begin
                rx_sr_q   <= rx_next;
                bit_cnt_q <= bit_cnt_q + 3'd1;
            end

            if (byte_done) begin
`ifdef SPI_TARGET_STATUS_EN
                got_byte_q <= 1'b1;
`endif
                case (state_q)
                    ST_CMD: begin
                        reg_addr_q <= rx_next[ADDR_W-1:0];
                        if (rx_next[7]) begin
                            state_q   <= ST_RD;
                            re_pend_q <= 1'b1;
                        end else begin
                            state_q   <= ST_WR;
                        end
                    end
                    ST_WR: begin
                        reg_we_q    <= 1'b1;
                        reg_wdata_q <= rx_next;
                    end
                    ST_RD: begin
                        reg_re_q <= 1'b1;
                    end
                    default: ;
                endcase
            end

            // MISO changes on falling SCK so it is stable for the master's rising-edge sample
            if (sck_fall) begin
                if (bit_cnt_q == 3'd0) begin
                    tx_sr_q <= (state_q == ST_RD) ? rd_buf_q : 8'h00;
                end else begin
                    tx_sr_q <= {tx_sr_q[6:0], 1'b0};
                end
            end

            if (cs_fall && (state_q == ST_IDLE)) begin
                state_q   <= ST_CMD;
                busy_q    <= 1'b1;
                bit_cnt_q <= 3'd0;
                rx_sr_q   <= 8'h00;
                tx_sr_q   <= status_byte;
`ifdef SPI_TARGET_STATUS_EN
                got_byte_q <= 1'b0;
`endif
            end

            // CS rise drops any partial byte and parks the pins
            if (cs_rise) begin
                state_q   <= ST_IDLE;
                busy_q    <= 1'b0;
                bit_cnt_q <= 3'd0;
                rx_sr_q   <= 8'h00;
                tx_sr_q   <= 8'h00;
`ifdef SPI_TARGET_STATUS_EN
                if (got_byte_q || byte_done) begin
                    xact_cnt_q <= xact_cnt_q + 4'd1;
                end
                got_byte_q <= 1'b0;
`endif
            end
        end
    end

    assign bus.spi_miso    = tx_sr_q[7];
    assign bus.spi_miso_oe = busy_q;
    assign bus.busy        = busy_q;
    assign bus.reg_addr    = reg_addr_q;
    assign bus.reg_wdata   = reg_wdata_q;
    assign bus.reg_we      = reg_we_q;
    assign bus.reg_re      = reg_re_q;

endmodule
